// File: rtl/controle_multiciclo_pkg.sv
// Shared definitions for the multicycle RV32I control unit and its datapath.
// Holds the FSM state encoding, the RV32I major opcodes, and the select
// encodings of oMem2Reg / oOrigAULA / oOrigBULA / oALUOp. The datapath
// imports the same package, so both sides decode these fields identically.
package controle_multiciclo_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADDR  = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    RTYPE    = 4'd6,
    ITYPE    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    LUI      = 4'd12,
    ILEGAL   = 4'd13
  } estado_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [1:0] MEM2REG_ALUOUT = 2'd0;
  localparam logic [1:0] MEM2REG_MDR    = 2'd1;
  localparam logic [1:0] MEM2REG_PC     = 2'd2;

  localparam logic [1:0] ORIGA_PC     = 2'd0;
  localparam logic [1:0] ORIGA_A      = 2'd1;
  localparam logic [1:0] ORIGA_PCBACK = 2'd2;
  localparam logic [1:0] ORIGA_ZERO   = 2'd3;

  localparam logic [1:0] ORIGB_B    = 2'd0;
  localparam logic [1:0] ORIGB_4    = 2'd1;
  localparam logic [1:0] ORIGB_IMM  = 2'd2;

  localparam logic [1:0] ALUOP_ADD    = 2'd0;
  localparam logic [1:0] ALUOP_BRANCH = 2'd1;
  localparam logic [1:0] ALUOP_RTYPE  = 2'd2;
  localparam logic [1:0] ALUOP_ITYPE  = 2'd3;

  // Maps an opcode to the state that follows DECODE; anything the core
  // does not implement lands in ILEGAL.
  function automatic estado_t decodeOpcode(input logic [6:0] opcode);
    case (opcode)
      OPC_LOAD, OPC_STORE: decodeOpcode = MEMADDR;
      OPC_OP:              decodeOpcode = RTYPE;
      OPC_OPIMM:           decodeOpcode = ITYPE;
      OPC_BRANCH:          decodeOpcode = BRANCH;
      OPC_JAL:             decodeOpcode = JAL;
      OPC_JALR:            decodeOpcode = JALR;
      OPC_LUI:             decodeOpcode = LUI;
      default:             decodeOpcode = ILEGAL;
    endcase
  endfunction

endpackage

// File: rtl/controle_multiciclo_contador.sv
// Free-running performance counter for the debug display.
// Ports: clockCPU (clock), clear (sync clear, wins over enable),
//        enable (count this cycle), valor (current count, wraps).
module contador_desempenho #(
  parameter int COUNT_W = 32
) (
  input  logic               clockCPU,
  input  logic               clear,
  input  logic               enable,
  output logic [COUNT_W-1:0] valor
);

  localparam logic [COUNT_W-1:0] UM = 1;

  // Clear has priority so a reset cycle never counts.
  always_ff @(posedge clockCPU) begin
    if (clear)
      valor <= '0;
    else if (enable)
      valor <= valor + UM;
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Main control FSM of the multicycle RV32I core. Steps each instruction
// through FETCH/DECODE/EXECUTE/MEM/WB and drives every mux select and write
// enable of the datapath. Memory steps wait on iMemPronta.
// Ports:
//   clockCPU, reset (sync, active high)
//   iOpcode     instruction register opcode field
//   iMemPronta  memory access completes this cycle
//   o*          datapath enables and selects (encodings in the package)
//   oIlegal     one-cycle pulse on an unsupported opcode
//   oEstado     current state, for debug
//   oNumInstr / oNumCiclos  instructions fetched / cycles since reset
module controle_multiciclo
  import controle_multiciclo_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic               clockCPU,
  input  logic               reset,
  input  logic [6:0]         iOpcode,
  input  logic               iMemPronta,
  output logic               oEscrevePC,
  output logic               oEscrevePCCond,
  output logic               oEscrevePCBack,
  output logic               oIouD,
  output logic               oLeMem,
  output logic               oEscreveMem,
  output logic               oEscreveIR,
  output logic               oEscreveReg,
  output logic [1:0]         oMem2Reg,
  output logic [1:0]         oOrigAULA,
  output logic [1:0]         oOrigBULA,
  output logic [1:0]         oALUOp,
  output logic               oOrigPC,
  output logic               oIlegal,
  output logic [3:0]         oEstado,
  output logic [COUNT_W-1:0] oNumInstr,
  output logic [COUNT_W-1:0] oNumCiclos
);

  estado_t estadoAtual;
  estado_t proximoEstado;
  logic    instrBuscada;

  // State register.
  always_ff @(posedge clockCPU) begin
    if (reset)
      estadoAtual <= FETCH;
    else
      estadoAtual <= proximoEstado;
  end

  // Next state and outputs. Everything defaults to 0; each state only
  // raises what it needs. Reset overrides all outputs so an abandoned
  // instruction cannot write anything.
  always_comb begin
    proximoEstado  = FETCH;
    oEscrevePC     = 1'b0;
    oEscrevePCCond = 1'b0;
    oEscrevePCBack = 1'b0;
    oIouD          = 1'b0;
    oLeMem         = 1'b0;
    oEscreveMem    = 1'b0;
    oEscreveIR     = 1'b0;
    oEscreveReg    = 1'b0;
    oMem2Reg       = MEM2REG_ALUOUT;
    oOrigAULA      = ORIGA_PC;
    oOrigBULA      = ORIGB_B;
    oALUOp         = ALUOP_ADD;
    oOrigPC        = 1'b0;
    oIlegal        = 1'b0;

    case (estadoAtual)
      FETCH: begin
        // PC+4 goes straight back into PC; IR, PC and PCBack only commit
        // once memory returns the instruction.
        oLeMem    = 1'b1;
        oIouD     = 1'b0;
        oOrigAULA = ORIGA_PC;
        oOrigBULA = ORIGB_4;
        oALUOp    = ALUOP_ADD;
        oOrigPC   = 1'b0;
        if (iMemPronta) begin
          oEscreveIR     = 1'b1;
          oEscrevePC     = 1'b1;
          oEscrevePCBack = 1'b1;
          proximoEstado  = DECODE;
        end else begin
          proximoEstado  = FETCH;
        end
      end
      DECODE: begin
        // Speculatively compute PCBack+imm so ALUOut holds the
        // branch/jump target for the next step.
        oOrigAULA     = ORIGA_PCBACK;
        oOrigBULA     = ORIGB_IMM;
        oALUOp        = ALUOP_ADD;
        proximoEstado = decodeOpcode(iOpcode);
      end
      MEMADDR: begin
        oOrigAULA     = ORIGA_A;
        oOrigBULA     = ORIGB_IMM;
        oALUOp        = ALUOP_ADD;
        proximoEstado = (iOpcode == OPC_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        oIouD         = 1'b1;
        oLeMem        = 1'b1;
        proximoEstado = iMemPronta ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        oEscreveReg   = 1'b1;
        oMem2Reg      = MEM2REG_MDR;
        proximoEstado = FETCH;
      end
      MEMWRITE: begin
        // Write strobe only in the completing cycle so memory sees one write.
        oIouD         = 1'b1;
        oEscreveMem   = iMemPronta;
        proximoEstado = iMemPronta ? FETCH : MEMWRITE;
      end
      RTYPE: begin
        oOrigAULA     = ORIGA_A;
        oOrigBULA     = ORIGB_B;
        oALUOp        = ALUOP_RTYPE;
        proximoEstado = ALUWB;
      end
      ITYPE: begin
        oOrigAULA     = ORIGA_A;
        oOrigBULA     = ORIGB_IMM;
        oALUOp        = ALUOP_ITYPE;
        proximoEstado = ALUWB;
      end
      LUI: begin
        oOrigAULA     = ORIGA_ZERO;
        oOrigBULA     = ORIGB_IMM;
        oALUOp        = ALUOP_ADD;
        proximoEstado = ALUWB;
      end
      ALUWB: begin
        oEscreveReg   = 1'b1;
        oMem2Reg      = MEM2REG_ALUOUT;
        proximoEstado = FETCH;
      end
      BRANCH: begin
        // ALU compares A and B; PC loads the target from ALUOut when the
        // datapath condition holds.
        oOrigAULA      = ORIGA_A;
        oOrigBULA      = ORIGB_B;
        oALUOp         = ALUOP_BRANCH;
        oEscrevePCCond = 1'b1;
        oOrigPC        = 1'b1;
        proximoEstado  = FETCH;
      end
      JAL: begin
        // PC already holds PC+4, which is the link value.
        oEscreveReg   = 1'b1;
        oMem2Reg      = MEM2REG_PC;
        oEscrevePC    = 1'b1;
        oOrigPC       = 1'b1;
        proximoEstado = FETCH;
      end
      JALR: begin
        // Link and jump share one edge: the register file captures the
        // pre-edge PC (PC+4) while PC loads rs1+imm straight from the ALU.
        oOrigAULA     = ORIGA_A;
        oOrigBULA     = ORIGB_IMM;
        oALUOp        = ALUOP_ADD;
        oOrigPC       = 1'b0;
        oEscrevePC    = 1'b1;
        oEscreveReg   = 1'b1;
        oMem2Reg      = MEM2REG_PC;
        proximoEstado = FETCH;
      end
      ILEGAL: begin
        oIlegal       = 1'b1;
        proximoEstado = FETCH;
      end
      default: begin
        proximoEstado = FETCH;
      end
    endcase

    if (reset) begin
      oEscrevePC     = 1'b0;
      oEscrevePCCond = 1'b0;
      oEscrevePCBack = 1'b0;
      oIouD          = 1'b0;
      oLeMem         = 1'b0;
      oEscreveMem    = 1'b0;
      oEscreveIR     = 1'b0;
      oEscreveReg    = 1'b0;
      oMem2Reg       = 2'd0;
      oOrigAULA      = 2'd0;
      oOrigBULA      = 2'd0;
      oALUOp         = 2'd0;
      oOrigPC        = 1'b0;
      oIlegal        = 1'b0;
    end
  end

  assign oEstado      = estadoAtual;
  assign instrBuscada = (estadoAtual == FETCH) && iMemPronta && !reset;

  contador_desempenho #(.COUNT_W(COUNT_W)) uContInstr (
    .clockCPU (clockCPU),
    .clear    (reset),
    .enable   (instrBuscada),
    .valor    (oNumInstr)
  );

  contador_desempenho #(.COUNT_W(COUNT_W)) uContCiclos (
    .clockCPU (clockCPU),
    .clear    (reset),
    .enable   (1'b1),
    .valor    (oNumCiclos)
  );

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed testbench for controle_multiciclo. Enables and selects are
// compared as packed groups:
//   en  = {EscrevePC, EscrevePCCond, EscrevePCBack, LeMem, EscreveMem,
//          EscreveIR, EscreveReg, Ilegal}
//   sel = {IouD, Mem2Reg[1:0], OrigAULA[1:0], OrigBULA[1:0], ALUOp[1:0], OrigPC}
// A second instance with a 4-bit counter width exercises counter wrap.
module tb_controle_multiciclo;

  logic        clockCPU;
  logic        reset;
  logic [6:0]  iOpcode;
  logic        iMemPronta;

  logic        oEscrevePC, oEscrevePCCond, oEscrevePCBack, oIouD, oLeMem;
  logic        oEscreveMem, oEscreveIR, oEscreveReg, oOrigPC, oIlegal;
  logic [1:0]  oMem2Reg, oOrigAULA, oOrigBULA, oALUOp;
  logic [3:0]  oEstado;
  logic [31:0] oNumInstr, oNumCiclos;

  logic        sEscrevePC, sEscrevePCCond, sEscrevePCBack, sIouD, sLeMem;
  logic        sEscreveMem, sEscreveIR, sEscreveReg, sOrigPC, sIlegal;
  logic [1:0]  sMem2Reg, sOrigAULA, sOrigBULA, sALUOp;
  logic [3:0]  sEstado;
  logic [3:0]  sNumInstr, sNumCiclos;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] expInstr = 0;
  logic [31:0] expCiclos = 0;

  wire [7:0] enObs  = {oEscrevePC, oEscrevePCCond, oEscrevePCBack, oLeMem,
                       oEscreveMem, oEscreveIR, oEscreveReg, oIlegal};
  wire [9:0] selObs = {oIouD, oMem2Reg, oOrigAULA, oOrigBULA, oALUOp, oOrigPC};

  localparam logic [9:0] SEL_F  = 10'b0_00_00_01_00_0;
  localparam logic [9:0] SEL_D  = 10'b0_00_10_10_00_0;
  localparam logic [9:0] SEL_MA = 10'b0_00_01_10_00_0;
  localparam logic [9:0] SEL_IO = 10'b1_00_00_00_00_0;

  controle_multiciclo #(.COUNT_W(32)) dut (
    .clockCPU(clockCPU), .reset(reset), .iOpcode(iOpcode), .iMemPronta(iMemPronta),
    .oEscrevePC(oEscrevePC), .oEscrevePCCond(oEscrevePCCond), .oEscrevePCBack(oEscrevePCBack),
    .oIouD(oIouD), .oLeMem(oLeMem), .oEscreveMem(oEscreveMem), .oEscreveIR(oEscreveIR),
    .oEscreveReg(oEscreveReg), .oMem2Reg(oMem2Reg), .oOrigAULA(oOrigAULA),
    .oOrigBULA(oOrigBULA), .oALUOp(oALUOp), .oOrigPC(oOrigPC), .oIlegal(oIlegal),
    .oEstado(oEstado), .oNumInstr(oNumInstr), .oNumCiclos(oNumCiclos)
  );

  controle_multiciclo #(.COUNT_W(4)) dutSmall (
    .clockCPU(clockCPU), .reset(reset), .iOpcode(iOpcode), .iMemPronta(iMemPronta),
    .oEscrevePC(sEscrevePC), .oEscrevePCCond(sEscrevePCCond), .oEscrevePCBack(sEscrevePCBack),
    .oIouD(sIouD), .oLeMem(sLeMem), .oEscreveMem(sEscreveMem), .oEscreveIR(sEscreveIR),
    .oEscreveReg(sEscreveReg), .oMem2Reg(sMem2Reg), .oOrigAULA(sOrigAULA),
    .oOrigBULA(sOrigBULA), .oALUOp(sALUOp), .oOrigPC(sOrigPC), .oIlegal(sIlegal),
    .oEstado(sEstado), .oNumInstr(sNumInstr), .oNumCiclos(sNumCiclos)
  );

  initial clockCPU = 1'b0;
  always #5 clockCPU = ~clockCPU;

  // Reference cycle count: every non-reset edge counts.
  always @(posedge clockCPU) begin
    if (reset) expCiclos <= 32'd0;
    else       expCiclos <= expCiclos + 32'd1;
  end

  task automatic test_reset();
    reset = 1'b1; iOpcode = 7'b0110011; iMemPronta = 1'b1;
    repeat (2) @(negedge clockCPU);
    #1;
    checks++; if (oEstado !== 4'd0) begin errors++; $display("[TB] FAIL reset_estado: got %0d expected 0", oEstado); end
    checks++; if (enObs !== 8'h00) begin errors++; $display("[TB] FAIL reset_en: got %h expected 00", enObs); end
    checks++; if (selObs !== 10'd0) begin errors++; $display("[TB] FAIL reset_sel: got %b expected 0", selObs); end
    checks++; if (oNumCiclos !== 32'd0 || oNumInstr !== 32'd0) begin errors++; $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", oNumInstr, oNumCiclos); end
    reset = 1'b0; expInstr = 0;
    #1;
    checks++; if (enObs !== 8'hB4) begin errors++; $display("[TB] FAIL reset_release_fetch_en: got %h expected b4", enObs); end
  endtask

  task automatic test_add();
    logic [3:0] expEst [0:3];
    logic [7:0] expEn  [0:3];
    logic [9:0] expSel [0:3];
    expEst = '{4'd0, 4'd1, 4'd6, 4'd8};
    expEn  = '{8'hB4, 8'h00, 8'h00, 8'h02};
    expSel = '{SEL_F, SEL_D, 10'b0_00_01_00_10_0, 10'b0};
    iOpcode = 7'b0110011; iMemPronta = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (oEstado !== expEst[i]) begin errors++; $display("[TB] FAIL add_estado step %0d: got %0d expected %0d", i, oEstado, expEst[i]); end
      checks++; if (enObs !== expEn[i]) begin errors++; $display("[TB] FAIL add_en step %0d: got %h expected %h", i, enObs, expEn[i]); end
      checks++; if (selObs !== expSel[i]) begin errors++; $display("[TB] FAIL add_sel step %0d: got %b expected %b", i, selObs, expSel[i]); end
      if (i == 1) begin
        checks++; if (oNumInstr !== expInstr) begin errors++; $display("[TB] FAIL add_numinstr: got %0d expected %0d", oNumInstr, expInstr); end
      end
      @(negedge clockCPU);
      if (expEst[i] == 4'd0) expInstr++;
    end
    #1;
    checks++; if (oEstado !== 4'd0) begin errors++; $display("[TB] FAIL add_back_to_fetch: got %0d expected 0", oEstado); end
    checks++; if (oNumCiclos !== expCiclos) begin errors++; $display("[TB] FAIL add_numciclos: got %0d expected %0d", oNumCiclos, expCiclos); end
  endtask

  task automatic test_load();
    logic [3:0]  expEst [0:6];
    logic [7:0]  expEn  [0:6];
    logic [9:0]  expSel [0:6];
    logic        rdy    [0:6];
    logic [31:0] inicio;
    expEst = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
    expEn  = '{8'hB4, 8'h00, 8'h00, 8'h10, 8'h10, 8'h10, 8'h02};
    expSel = '{SEL_F, SEL_D, SEL_MA, SEL_IO, SEL_IO, SEL_IO, 10'b0_01_00_00_00_0};
    rdy    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    iOpcode = 7'b0000011;
    inicio = expCiclos;
    for (int i = 0; i < 7; i++) begin
      iMemPronta = rdy[i];
      #1;
      checks++; if (oEstado !== expEst[i]) begin errors++; $display("[TB] FAIL lw_estado step %0d: got %0d expected %0d", i, oEstado, expEst[i]); end
      checks++; if (enObs !== expEn[i]) begin errors++; $display("[TB] FAIL lw_en step %0d: got %h expected %h", i, enObs, expEn[i]); end
      checks++; if (selObs !== expSel[i]) begin errors++; $display("[TB] FAIL lw_sel step %0d: got %b expected %b", i, selObs, expSel[i]); end
      @(negedge clockCPU);
      if (expEst[i] == 4'd0 && rdy[i]) expInstr++;
    end
    iMemPronta = 1'b1;
    #1;
    checks++; if (oEstado !== 4'd0) begin errors++; $display("[TB] FAIL lw_back_to_fetch: got %0d expected 0", oEstado); end
    checks++; if (oNumCiclos !== inicio + 32'd7) begin errors++; $display("[TB] FAIL lw_cycles: got %0d expected %0d", oNumCiclos, inicio + 32'd7); end
    checks++; if (oNumInstr !== expInstr) begin errors++; $display("[TB] FAIL lw_numinstr: got %0d expected %0d", oNumInstr, expInstr); end
  endtask

  task automatic test_reset_mid();
    iOpcode = 7'b0000011; iMemPronta = 1'b1;
    repeat (3) @(negedge clockCPU);
    iMemPronta = 1'b0;
    #1;
    checks++; if (oEstado !== 4'd3) begin errors++; $display("[TB] FAIL rstmid_in_memread: got %0d expected 3", oEstado); end
    reset = 1'b1; iMemPronta = 1'b1;
    #1;
    checks++; if (enObs !== 8'h00 || selObs !== 10'd0) begin errors++; $display("[TB] FAIL rstmid_forced_zero: got %h/%b expected 00/0", enObs, selObs); end
    @(negedge clockCPU); #1;
    checks++; if (oEstado !== 4'd0) begin errors++; $display("[TB] FAIL rstmid_estado: got %0d expected 0", oEstado); end
    checks++; if (oNumCiclos !== 32'd0 || oNumInstr !== 32'd0) begin errors++; $display("[TB] FAIL rstmid_counters: got %0d/%0d expected 0/0", oNumInstr, oNumCiclos); end
    checks++; if (enObs !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_fetch_en_in_reset: got %h expected 00", enObs); end
    @(negedge clockCPU); #1;
    checks++; if (enObs !== 8'h00 || oNumCiclos !== 32'd0) begin errors++; $display("[TB] FAIL rstmid_second_cycle: got %h/%0d expected 00/0", enObs, oNumCiclos); end
    reset = 1'b0; expInstr = 0;
  endtask

  task automatic test_store();
    logic [3:0] expEst [0:6];
    logic [7:0] expEn  [0:6];
    logic [9:0] expSel [0:6];
    logic       rdy    [0:6];
    int         pulsos;
    expEst = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd5};
    expEn  = '{8'h10, 8'h10, 8'h10, 8'hB4, 8'h00, 8'h00, 8'h08};
    expSel = '{SEL_F, SEL_F, SEL_F, SEL_F, SEL_D, SEL_MA, SEL_IO};
    rdy    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    iOpcode = 7'b0100011;
    pulsos = 0;
    for (int i = 0; i < 7; i++) begin
      iMemPronta = rdy[i];
      #1;
      if (oEscreveMem === 1'b1) pulsos++;
      checks++; if (oEstado !== expEst[i]) begin errors++; $display("[TB] FAIL sw_estado step %0d: got %0d expected %0d", i, oEstado, expEst[i]); end
      checks++; if (enObs !== expEn[i]) begin errors++; $display("[TB] FAIL sw_en step %0d: got %h expected %h", i, enObs, expEn[i]); end
      checks++; if (selObs !== expSel[i]) begin errors++; $display("[TB] FAIL sw_sel step %0d: got %b expected %b", i, selObs, expSel[i]); end
      @(negedge clockCPU);
      if (expEst[i] == 4'd0 && rdy[i]) expInstr++;
    end
    #1;
    checks++; if (pulsos != 1) begin errors++; $display("[TB] FAIL sw_write_pulses: got %0d expected 1", pulsos); end
    checks++; if (oEstado !== 4'd0) begin errors++; $display("[TB] FAIL sw_back_to_fetch: got %0d expected 0", oEstado); end
    checks++; if (oNumInstr !== expInstr) begin errors++; $display("[TB] FAIL sw_numinstr: got %0d expected %0d", oNumInstr, expInstr); end
  endtask

  task automatic test_jal_jalr();
    logic [3:0] expEst [0:5];
    logic [7:0] expEn  [0:5];
    logic [9:0] expSel [0:5];
    logic [6:0] opc    [0:5];
    expEst = '{4'd0, 4'd1, 4'd10, 4'd0, 4'd1, 4'd11};
    expEn  = '{8'hB4, 8'h00, 8'h82, 8'hB4, 8'h00, 8'h82};
    expSel = '{SEL_F, SEL_D, 10'b0_10_00_00_00_1, SEL_F, SEL_D, 10'b0_10_01_10_00_0};
    opc    = '{7'b1101111, 7'b1101111, 7'b1101111, 7'b1100111, 7'b1100111, 7'b1100111};
    iMemPronta = 1'b1;
    for (int i = 0; i < 6; i++) begin
      iOpcode = opc[i];
      #1;
      checks++; if (oEstado !== expEst[i]) begin errors++; $display("[TB] FAIL jump_estado step %0d: got %0d expected %0d", i, oEstado, expEst[i]); end
      checks++; if (enObs !== expEn[i]) begin errors++; $display("[TB] FAIL jump_en step %0d: got %h expected %h", i, enObs, expEn[i]); end
      checks++; if (selObs !== expSel[i]) begin errors++; $display("[TB] FAIL jump_sel step %0d: got %b expected %b", i, selObs, expSel[i]); end
      @(negedge clockCPU);
      if (expEst[i] == 4'd0) expInstr++;
    end
    #1;
    checks++; if (oEstado !== 4'd0) begin errors++; $display("[TB] FAIL jump_back_to_fetch: got %0d expected 0", oEstado); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] expEst [0:10];
    logic [7:0] expEn  [0:10];
    logic [9:0] expSel [0:10];
    logic [6:0] opc    [0:10];
    expEst = '{4'd0, 4'd1, 4'd9, 4'd0, 4'd1, 4'd7, 4'd8, 4'd0, 4'd1, 4'd12, 4'd8};
    expEn  = '{8'hB4, 8'h00, 8'h40, 8'hB4, 8'h00, 8'h00, 8'h02, 8'hB4, 8'h00, 8'h00, 8'h02};
    expSel = '{SEL_F, SEL_D, 10'b0_00_01_00_01_1, SEL_F, SEL_D, 10'b0_00_01_10_11_0, 10'b0,
               SEL_F, SEL_D, 10'b0_00_11_10_00_0, 10'b0};
    opc    = '{7'b1100011, 7'b1100011, 7'b1100011, 7'b0010011, 7'b0010011, 7'b0010011,
               7'b0010011, 7'b0110111, 7'b0110111, 7'b0110111, 7'b0110111};
    iMemPronta = 1'b1;
    for (int i = 0; i < 11; i++) begin
      iOpcode = opc[i];
      #1;
      checks++; if (oEstado !== expEst[i]) begin errors++; $display("[TB] FAIL b2b_estado step %0d: got %0d expected %0d", i, oEstado, expEst[i]); end
      checks++; if (enObs !== expEn[i]) begin errors++; $display("[TB] FAIL b2b_en step %0d: got %h expected %h", i, enObs, expEn[i]); end
      checks++; if (selObs !== expSel[i]) begin errors++; $display("[TB] FAIL b2b_sel step %0d: got %b expected %b", i, selObs, expSel[i]); end
      @(negedge clockCPU);
      if (expEst[i] == 4'd0) expInstr++;
    end
    #1;
    checks++; if (oNumInstr !== expInstr) begin errors++; $display("[TB] FAIL b2b_numinstr: got %0d expected %0d", oNumInstr, expInstr); end
    checks++; if (oNumCiclos !== expCiclos) begin errors++; $display("[TB] FAIL b2b_numciclos: got %0d expected %0d", oNumCiclos, expCiclos); end
  endtask

  task automatic test_ilegal();
    logic [3:0] expEst [0:2];
    logic [7:0] expEn  [0:2];
    logic [9:0] expSel [0:2];
    expEst = '{4'd0, 4'd1, 4'd13};
    expEn  = '{8'hB4, 8'h00, 8'h01};
    expSel = '{SEL_F, SEL_D, 10'b0};
    iOpcode = 7'b1111111; iMemPronta = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (oEstado !== expEst[i]) begin errors++; $display("[TB] FAIL ilegal_estado step %0d: got %0d expected %0d", i, oEstado, expEst[i]); end
      checks++; if (enObs !== expEn[i]) begin errors++; $display("[TB] FAIL ilegal_en step %0d: got %h expected %h", i, enObs, expEn[i]); end
      checks++; if (selObs !== expSel[i]) begin errors++; $display("[TB] FAIL ilegal_sel step %0d: got %b expected %b", i, selObs, expSel[i]); end
      @(negedge clockCPU);
      if (expEst[i] == 4'd0) expInstr++;
    end
    #1;
    checks++; if (oEstado !== 4'd0 || oIlegal !== 1'b0) begin errors++; $display("[TB] FAIL ilegal_next_fetch: got %0d/%b expected 0/0", oEstado, oIlegal); end
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    @(negedge clockCPU); #1;
    reset = 1'b0; expInstr = 0;
    iOpcode = 7'b1111111; iMemPronta = 1'b1;
    repeat (15) @(negedge clockCPU);
    #1;
    checks++; if (sNumCiclos !== 4'hF) begin errors++; $display("[TB] FAIL wrap_ciclos_allones: got %h expected f", sNumCiclos); end
    @(negedge clockCPU); #1;
    checks++; if (sNumCiclos !== 4'h0) begin errors++; $display("[TB] FAIL wrap_ciclos_zero: got %h expected 0", sNumCiclos); end
    checks++; if (oNumCiclos !== 32'd16) begin errors++; $display("[TB] FAIL wrap_ciclos_wide: got %0d expected 16", oNumCiclos); end
    repeat (27) @(negedge clockCPU);
    #1;
    checks++; if (sNumInstr !== 4'hF) begin errors++; $display("[TB] FAIL wrap_instr_allones: got %h expected f", sNumInstr); end
    repeat (3) @(negedge clockCPU);
    #1;
    checks++; if (sNumInstr !== 4'h0) begin errors++; $display("[TB] FAIL wrap_instr_zero: got %h expected 0", sNumInstr); end
    checks++; if (oNumInstr !== 32'd16) begin errors++; $display("[TB] FAIL wrap_instr_wide: got %0d expected 16", oNumInstr); end
  endtask

  initial begin
    reset = 1'b1; iOpcode = 7'd0; iMemPronta = 1'b0;
    test_reset();
    test_add();
    test_load();
    test_reset_mid();
    test_store();
    test_jal_jalr();
    test_back_to_back();
    test_ilegal();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
